// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: multicycle-op sequencing, load-use stall,
// taken-branch flush and operand forwarding selection for a 5-stage pipe.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs_a_id,
  input  logic [4:0] rs_b_id,
  input  logic [4:0] rs_a_ex,
  input  logic [4:0] rs_b_ex,
  input  logic [4:0] rw_ex,
  input  logic       wr_en_ex,
  input  logic       wd_sel_ex,
  input  logic [4:0] rw_mem,
  input  logic       wr_en_mem,
  input  logic [4:0] rw_wb,
  input  logic       wr_en_wb,
  input  logic       mc_start_ex,
  input  logic       branch_taken_ex,
  output logic       stall_if,
  output logic       stall_id,
  output logic       hold_ex,
  output logic       bubble_ex,
  output logic       bubble_mem,
  output logic       flush_id,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       mc_busy,
  output logic       mc_done
);

  typedef enum logic [1:0] {IDLE, MC_RUN, MC_DONE} state_t;

  // Start cycle and MC_DONE cycle are counted outside MC_RUN, hence -3.
  localparam logic [7:0] CNT_LOAD = (MC_LAT > 2) ? 8'(MC_LAT - 3) : 8'd0;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       mc_go;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rwm, input logic enm,
                                         input logic [4:0] rww, input logic enw);
    if (enm && rwm != 5'd0 && rwm == rs)      return 2'b01;
    else if (enw && rww != 5'd0 && rww == rs) return 2'b10;
    else                                      return 2'b00;
  endfunction

  // State and counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and counter update; a taken branch blocks a multicycle start
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mc_go    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mc_start_ex && !branch_taken_ex) begin
          mc_go = 1'b1;
          if (MC_LAT <= 2) begin
            state_nx = MC_DONE;
          end else begin
            state_nx = MC_RUN;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      MC_RUN: begin
        if (cnt == 8'd0) state_nx = MC_DONE;
        else             cnt_nx   = cnt - 8'd1;
      end
      MC_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Hazard outputs; busy dominates branch, branch dominates load-use, reset forces all low
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    hold_ex    = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    flush_id   = 1'b0;
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    mc_busy    = 1'b0;
    mc_done    = 1'b0;
    load_use   = wr_en_ex && wd_sel_ex && rw_ex != 5'd0 &&
                 (rw_ex == rs_a_id || rw_ex == rs_b_id);
    if (!reset) begin
      mc_busy   = mc_go || state == MC_RUN;
      mc_done   = state == MC_DONE;
      fwd_a_sel = fwd_sel(rs_a_ex, rw_mem, wr_en_mem, rw_wb, wr_en_wb);
      fwd_b_sel = fwd_sel(rs_b_ex, rw_mem, wr_en_mem, rw_wb, wr_en_wb);
      if (mc_busy) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        hold_ex    = 1'b1;
        bubble_mem = 1'b1;
      end else if (branch_taken_ex) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MC_LAT=8 main instance, MC_LAT=2 second instance).
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs_a_id, rs_b_id, rs_a_ex, rs_b_ex, rw_ex, rw_mem, rw_wb;
  logic       wr_en_ex, wd_sel_ex, wr_en_mem, wr_en_wb, mc_start_ex, branch_taken_ex;
  logic       mc_start2;

  logic       stall_if, stall_id, hold_ex, bubble_ex, bubble_mem, flush_id, mc_busy, mc_done;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if2, stall_id2, hold_ex2, bubble_ex2, bubble_mem2, flush_id2, mc_busy2, mc_done2;
  logic [1:0] fwd_a_sel2, fwd_b_sel2;

  // {stall_if,stall_id,hold_ex,bubble_ex,bubble_mem,flush_id,fwd_a[1:0],fwd_b[1:0],mc_busy,mc_done}
  logic [11:0] outs, outs2;
  assign outs  = {stall_if, stall_id, hold_ex, bubble_ex, bubble_mem, flush_id,
                  fwd_a_sel, fwd_b_sel, mc_busy, mc_done};
  assign outs2 = {stall_if2, stall_id2, hold_ex2, bubble_ex2, bubble_mem2, flush_id2,
                  fwd_a_sel2, fwd_b_sel2, mc_busy2, mc_done2};

  localparam logic [11:0] O_BUSY   = 12'hE82;
  localparam logic [11:0] O_DONE   = 12'h001;
  localparam logic [11:0] O_LU     = 12'hD00;
  localparam logic [11:0] O_BRANCH = 12'h140;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MC_LAT(8)) dut (
    .clock(clock), .reset(reset),
    .rs_a_id(rs_a_id), .rs_b_id(rs_b_id), .rs_a_ex(rs_a_ex), .rs_b_ex(rs_b_ex),
    .rw_ex(rw_ex), .wr_en_ex(wr_en_ex), .wd_sel_ex(wd_sel_ex),
    .rw_mem(rw_mem), .wr_en_mem(wr_en_mem), .rw_wb(rw_wb), .wr_en_wb(wr_en_wb),
    .mc_start_ex(mc_start_ex), .branch_taken_ex(branch_taken_ex),
    .stall_if(stall_if), .stall_id(stall_id), .hold_ex(hold_ex), .bubble_ex(bubble_ex),
    .bubble_mem(bubble_mem), .flush_id(flush_id), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .mc_busy(mc_busy), .mc_done(mc_done)
  );

  pipe_hazard_ctrl #(.MC_LAT(2)) dut2 (
    .clock(clock), .reset(reset),
    .rs_a_id(rs_a_id), .rs_b_id(rs_b_id), .rs_a_ex(rs_a_ex), .rs_b_ex(rs_b_ex),
    .rw_ex(rw_ex), .wr_en_ex(wr_en_ex), .wd_sel_ex(wd_sel_ex),
    .rw_mem(rw_mem), .wr_en_mem(wr_en_mem), .rw_wb(rw_wb), .wr_en_wb(wr_en_wb),
    .mc_start_ex(mc_start2), .branch_taken_ex(branch_taken_ex),
    .stall_if(stall_if2), .stall_id(stall_id2), .hold_ex(hold_ex2), .bubble_ex(bubble_ex2),
    .bubble_mem(bubble_mem2), .flush_id(flush_id2), .fwd_a_sel(fwd_a_sel2),
    .fwd_b_sel(fwd_b_sel2), .mc_busy(mc_busy2), .mc_done(mc_done2)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs_a_id = '0; rs_b_id = '0; rs_a_ex = '0; rs_b_ex = '0;
    rw_ex = '0; rw_mem = '0; rw_wb = '0;
    wr_en_ex = 1'b0; wd_sel_ex = 1'b0; wr_en_mem = 1'b0; wr_en_wb = 1'b0;
    mc_start_ex = 1'b0; branch_taken_ex = 1'b0; mc_start2 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with every hazard condition active: all outputs low
    clr();
    reset = 1'b1;
    mc_start_ex = 1'b1; mc_start2 = 1'b1; branch_taken_ex = 1'b1;
    rs_a_ex = 5'd3; rw_mem = 5'd3; wr_en_mem = 1'b1;
    wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rw_ex = 5'd3; rs_a_id = 5'd3;
    #2;
    chk("rst_outs", outs, 12'h000);
    chk("rst_outs2", outs2, 12'h000);
    cyc();
    clr();
    reset = 1'b0;
    #1 chk("idle", outs, 12'h000);

    // MC_LAT=8 with start held: 7 busy cycles, done on 8th, idle on 9th
    cyc(); mc_start_ex = 1'b1;
    #1 chk("mc8_c1", outs, O_BUSY);
    for (int i = 2; i <= 7; i++) begin
      cyc();
      if (i == 4) begin
        branch_taken_ex = 1'b1; rs_a_ex = 5'd7; rw_wb = 5'd7; wr_en_wb = 1'b1;
        #1 chk("mc8_busy_branch_fwd", outs, 12'hEA2);
      end else begin
        branch_taken_ex = 1'b0; rs_a_ex = '0; rw_wb = '0; wr_en_wb = 1'b0;
        #1 chk($sformatf("mc8_c%0d", i), outs, O_BUSY);
      end
    end
    cyc();
    #1 chk("mc8_c8_done", outs, O_DONE);
    cyc(); mc_start_ex = 1'b0;
    #1 chk("mc8_c9_idle", outs, 12'h000);

    // Load-use stall then forwarded operand with no stall
    cyc(); clr();
    wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rw_ex = 5'd5; rs_b_id = 5'd5;
    #1 chk("lu_stall", outs, O_LU);
    cyc(); clr();
    rw_mem = 5'd5; wr_en_mem = 1'b1; rs_b_ex = 5'd5;
    #1 chk("lu_next", outs, 12'h004);
    cyc(); clr();
    wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rw_ex = 5'd0; rs_a_id = 5'd0;
    #1 chk("lu_r0", outs, 12'h000);
    cyc(); clr();
    wr_en_ex = 1'b1; wd_sel_ex = 1'b0; rw_ex = 5'd9; rs_a_id = 5'd9;
    #1 chk("lu_not_load", outs, 12'h000);

    // Forwarding priority and register 0
    cyc(); clr();
    rs_a_ex = 5'd3; rw_mem = 5'd3; wr_en_mem = 1'b1; rw_wb = 5'd3; wr_en_wb = 1'b1;
    #1 chk("fwd_mem_prio", outs, 12'h010);
    rw_mem = 5'd0;
    #1 chk("fwd_wb", outs, 12'h020);
    rw_mem = 5'd3; wr_en_mem = 1'b0;
    #1 chk("fwd_mem_disabled", outs, 12'h020);
    clr(); wr_en_mem = 1'b1; wr_en_wb = 1'b1;
    #1 chk("fwd_r0", outs, 12'h000);
    clr();
    rs_a_ex = 5'd4; rs_b_ex = 5'd9; rw_mem = 5'd9; wr_en_mem = 1'b1; rw_wb = 5'd4; wr_en_wb = 1'b1;
    #1 chk("fwd_both", outs, 12'h024);

    // Branch overrides load-use; branch beats multicycle start
    cyc(); clr();
    wr_en_ex = 1'b1; wd_sel_ex = 1'b1; rw_ex = 5'd6; rs_a_id = 5'd6; branch_taken_ex = 1'b1;
    #1 chk("branch_over_lu", outs, O_BRANCH);
    cyc(); clr();
    mc_start_ex = 1'b1; branch_taken_ex = 1'b1;
    #1 chk("branch_over_mc", outs, O_BRANCH);
    cyc(); clr();
    #1 chk("mc_not_started", outs, 12'h000);

    // MC_LAT=2: one busy cycle, one done cycle (start ignored), then idle
    cyc(); clr(); mc_start2 = 1'b1;
    #1 chk("mc2_busy", outs2, O_BUSY);
    cyc();
    #1 chk("mc2_done", outs2, O_DONE);
    cyc(); mc_start2 = 1'b0;
    #1 chk("mc2_idle", outs2, 12'h000);

    // Reset during 4th MC_RUN cycle abandons the operation
    cyc(); clr(); mc_start_ex = 1'b1;
    #1 chk("rmc_start", outs, O_BUSY);
    for (int k = 1; k <= 4; k++) cyc();
    #1 chk("rmc_run4", outs, O_BUSY);
    reset = 1'b1; rs_a_ex = 5'd3; rw_mem = 5'd3; wr_en_mem = 1'b1;
    #1 chk("rmc_reset_now", outs, 12'h000);
    cyc();
    chk("rmc_reset_edge", outs, 12'h000);
    clr();
    reset = 1'b0;
    #1 chk("rmc_released", outs, 12'h000);
    cyc();
    chk("rmc_idle1", outs, 12'h000);
    cyc();
    chk("rmc_idle2", outs, 12'h000);
    mc_start_ex = 1'b1;
    #1 chk("rmc_restart", outs, O_BUSY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MC_LAT, default 8: total cycles a multicycle (modular multiply) instruction occupies EX; legal range 2..255.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rs_a_id, rs_b_id  in  5 each  source register numbers of the instruction in ID.
REQ-005 rs_a_ex, rs_b_ex  in  5 each  source register numbers of the instruction in EX.
REQ-006 rw_ex, wr_en_ex, wd_sel_ex  in  5/1/1  EX destination, register-write enable, load select (1 = result from memory).
REQ-007 rw_mem, wr_en_mem  in  5/1  MEM-stage destination and write enable, taken from the EX/MEM pipe register.
REQ-008 rw_wb, wr_en_wb  in  5/1  WB-stage destination and write enable.
REQ-009 mc_start_ex  in  1  instruction in EX is a multicycle operation.
REQ-010 branch_taken_ex  in  1  branch resolved taken in EX.
REQ-011 stall_if, stall_id  out  1 each  hold PC and IF/ID register.
REQ-012 hold_ex  out  1  hold ID/EX register contents.
REQ-013 bubble_ex  out  1  load zero controls into ID/EX.
REQ-014 bubble_mem  out  1  load zero wr_en/wm_en into EX/MEM.
REQ-015 flush_id  out  1  squash IF/ID contents.
REQ-016 fwd_a_sel, fwd_b_sel  out  2 each  operand source: 00 register file, 01 EX/MEM ALU result, 10 WB data.
REQ-017 mc_busy, mc_done  out  1 each  multicycle operation in progress / final cycle.

Function
REQ-018 FSM states IDLE, MC_RUN, MC_DONE; 8-bit down-counter cnt.
REQ-019 IDLE with mc_start_ex=1 and branch_taken_ex=0: next state MC_DONE if MC_LAT=2, else MC_RUN with cnt loaded to MC_LAT-3.
REQ-020 MC_RUN: cnt=0 -> MC_DONE; otherwise cnt decrements and state holds.
REQ-021 MC_DONE -> IDLE unconditionally; mc_start_ex is ignored in MC_DONE (same instruction still in EX).
REQ-022 mc_busy=1 in the IDLE start cycle of REQ-019 and in every MC_RUN cycle; mc_done=1 only in MC_DONE; EX occupancy is exactly MC_LAT cycles.
REQ-023 While mc_busy=1: stall_if=stall_id=hold_ex=bubble_mem=1, bubble_ex=flush_id=0; branch_taken_ex and load-use are ignored.
REQ-024 Branch (mc_busy=0, branch_taken_ex=1): flush_id=1, bubble_ex=1, no stalls; overrides load-use in the same cycle.
REQ-025 mc_start_ex and branch_taken_ex asserted together in IDLE: branch wins and the multicycle operation does not start.
REQ-026 Load-use (no busy, no branch): wr_en_ex & wd_sel_ex & rw_ex!=0 & (rw_ex==rs_a_id | rw_ex==rs_b_id) -> stall_if=stall_id=bubble_ex=1 for that cycle only.
REQ-027 Forwarding per operand: match rw_mem with wr_en_mem=1 and rw_mem!=0 -> 01; else match rw_wb with wr_en_wb=1 and rw_wb!=0 -> 10; else 00; MEM has priority over WB.
REQ-028 Forwarding is combinational and stays valid during stalls; register 0 never forwards and never stalls.
REQ-029 All outputs except the FSM and counter are combinational; no output depends on a previous-cycle value other than FSM state.

Reset
REQ-030 reset=1 immediately forces state IDLE, cnt=0 and all outputs 0 regardless of inputs, including mid-multicycle.
REQ-031 First rising edge after reset deassertion evaluates from IDLE; an in-flight multicycle operation is abandoned, not resumed.

Verification
REQ-032 MC_LAT=8, mc_start_ex=1 held: mc_busy=1 for 7 cycles, mc_done=1 on cycle 8, stalls drop on cycle 8, IDLE on cycle 9.
REQ-033 MC_LAT=2: one busy cycle, then one MC_DONE cycle, then IDLE.
REQ-034 Load in EX with rw_ex=5, rs_b_id=5: one cycle with stall_if=stall_id=bubble_ex=1; next cycle rw_mem=5 with no stall.
REQ-035 rs_a_ex=3, rw_mem=3, wr_en_mem=1, rw_wb=3, wr_en_wb=1: fwd_a_sel=01; repeated with rw_mem=0: fwd_a_sel=10.
REQ-036 branch_taken_ex=1 together with a load-use match: flush_id=1, bubble_ex=1, stall_if=0.
REQ-037 reset pulsed in the 4th MC_RUN cycle: outputs 0 immediately; state IDLE after release; mc_busy=0 until a new mc_start_ex.
